wb_write_scheduler: RTL and testbench
=====================================

# wb_write_scheduler

Parametrised writeback scheduler that owns the single register-file write port. It decodes the writeback-stage opcode into write address and enable, and redirects `jal`, `setx` and overflow writes to the link and status registers. It also tracks one in-flight multi-cycle mult/div result, arbitrating it onto the port and raising a decode-stage hazard while it is outstanding. It sits between the W stage, the multdiv unit and the register file.

## Interface
- `ADDR_W`, 5: register address width
- `DATA_W`, 32: data width
- `LINK_REG`, 31: `jal` destination
- `STATUS_REG`, 30: `setx` / exception destination
- `clock`  in  1  system clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `w_valid`  in  1  W-stage instruction valid
- `w_opcode`  in  5  W-stage opcode
- `w_rd`  in  ADDR_W  W-stage $rd
- `w_data`  in  DATA_W  ALU/load result
- `w_pc1`  in  DATA_W  PC+1 of W-stage instruction
- `w_target`  in  DATA_W  `setx` immediate (zero-extended)
- `w_exc`  in  1  overflow exception on W-stage instruction
- `w_exc_code`  in  DATA_W  status value for exception
- `md_start`  in  1  mult/div issued this cycle
- `md_rd`  in  ADDR_W  destination of issued mult/div
- `md_done`  in  1  mult/div result valid (1-cycle pulse)
- `md_result`  in  DATA_W  mult/div result
- `md_exc`  in  1  mult/div exception (write status instead)
- `d_rs`, `d_rt`, `d_rd`  in  ADDR_W  decode-stage operand/dest addresses
- `hazard`  out  1  decode must stall
- `rf_we`  out  1  register-file write enable
- `rf_waddr`  out  ADDR_W  write address
- `rf_wdata`  out  DATA_W  write data

## Operation
- Opcode classes: `jal` 00011 → addr LINK_REG, data `w_pc1`; `setx` 10101 → STATUS_REG, `w_target`; no-write: 00001, 00010, 00100, 00110, 00111, 10110; all others → `w_rd`, `w_data`.
- `w_exc` overrides the class: addr STATUS_REG, data `w_exc_code`, enabled even if `w_rd`=0.
- Any write resolving to address 0 is suppressed (nop rule). This includes normal-class writes with `w_rd`=0 and mult/div completions with `md_rd`=0.
- FSM states:
  - IDLE
  - BUSY: mult/div outstanding; dest latched
  - HOLD: result captured, waiting for the port
- IDLE → BUSY on `md_start`.
- BUSY on `md_done`:
  - → IDLE, driving the write that cycle, if the W stage produces no enabled write.
  - → HOLD, capturing the result into a 1-entry buffer, otherwise.
- HOLD → IDLE on the first cycle with no enabled W-stage write; the buffer drains then.
- W stage always has port priority. Mult/div data uses the latched dest, or STATUS_REG if `md_exc`.
- `hazard` = state≠IDLE and (`d_rs`, `d_rt` or `d_rd` equals the latched dest, with dest≠0), or `md_start` is seen while state≠IDLE.
- `md_start` while not IDLE is a protocol violation; it is ignored (state unchanged), and the decode stall prevents it in practice.
- `md_done` in IDLE or HOLD is ignored.

## Timing
- Port outputs are registered: a write decided in cycle N appears on `rf_*` in cycle N+1, for one cycle.
- `hazard` is combinational from state and the decode inputs; zero latency.
- Mult/div result reaches `rf_*` one cycle after `md_done` if the port is free, otherwise one cycle after the first free cycle.
- When `md_done` and `md_start` coincide, the FSM goes BUSY→IDLE or HOLD; the new start is not accepted.
- Reset (asynchronous, any time, including mid-mult/div):
  - state IDLE, buffer invalid, latched dest 0
  - `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `hazard`=0
  - an in-flight result is discarded.

## Structure
- Shared package `proc_pkg` holds opcode constants (OP_J, OP_BNE, OP_JAL, OP_JR, OP_BLT, OP_SW, OP_SETX, OP_BEX) and the FSM state encoding (IDLE=2'd0, BUSY=2'd1, HOLD=2'd2).
- One sub-module, `wb_decode`: the combinational opcode → {en, addr-select, data-select} decoder, parametrised by ADDR_W/LINK_REG/STATUS_REG.
- FSM, hold buffer and output registers live in the top module.

## Test plan
- Basic decode:
  - `jal`, `w_pc1`=0x40 → next cycle `rf_we`=1, addr 31, data 0x40.
  - `sw` → `rf_we`=0.
  - ALU op with `w_rd`=0 → `rf_we`=0.
- Exception: ALU op with `w_rd`=5, `w_exc`=1, code 1 → addr 30, data 1.
- Hazard: `md_start` with `md_rd`=7, then `d_rs`=7 → `hazard`=1.
  - `d_rs`=8 → `hazard`=0.
  - `md_done` with result 0x99, port free → addr 7, data 0x99 next cycle; `hazard` clears.
- Collision: `md_done` in the same cycle as ALU write to r3 → r3 written first, r7 written the following cycle; state passes through HOLD.
- Reset mid-mult/div: assert `reset_n`=0 while BUSY → outputs 0 immediately; a later `md_done` produces no write.
- Parameters: ADDR_W=6, LINK_REG=63 → `jal` writes addr 63.

Source files
------------

// File: rtl/proc_pkg.sv
// proc_pkg: opcode constants, FSM encoding and writeback data-select codes
package proc_pkg;
    localparam logic [4:0] OP_J    = 5'b00001;
    localparam logic [4:0] OP_BNE  = 5'b00010;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_JR   = 5'b00100;
    localparam logic [4:0] OP_BLT  = 5'b00110;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_SETX = 5'b10101;
    localparam logic [4:0] OP_BEX  = 5'b10110;
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, HOLD = 2'd2} state_t;
    typedef enum logic [1:0] {DSEL_DATA, DSEL_PC1, DSEL_TARGET, DSEL_EXC} dsel_t;
endpackage

// File: rtl/wb_decode.sv
// wb_decode: W-stage opcode -> write enable, destination address, data select
// ports: opcode/exc/rd in; en (before the r0 nop rule), addr, dsel out
module wb_decode
    import proc_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int LINK_REG   = 31,
    parameter int STATUS_REG = 30
) (
    input  logic [4:0]        opcode,
    input  logic              exc,
    input  logic [ADDR_W-1:0] rd,
    output logic              en,
    output logic [ADDR_W-1:0] addr,
    output dsel_t             dsel
);
    localparam logic [ADDR_W-1:0] LINK_A   = ADDR_W'(LINK_REG);
    localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(STATUS_REG);
    always_comb begin
        en   = exc || !(opcode inside {OP_J, OP_BNE, OP_JR, OP_BLT, OP_SW, OP_BEX});
        addr = (exc || opcode == OP_SETX) ? STATUS_A : (opcode == OP_JAL) ? LINK_A : rd;
        dsel = exc ? DSEL_EXC : (opcode == OP_JAL) ? DSEL_PC1 :
               (opcode == OP_SETX) ? DSEL_TARGET : DSEL_DATA;
    end
endmodule

// File: rtl/wb_write_scheduler.sv
// wb_write_scheduler: arbitrates W-stage and one in-flight mult/div result onto the register-file write port
// ports: W-stage inputs (w_*), mult/div handshake (md_*), decode addresses (d_*);
//        hazard (combinational stall), rf_we/rf_waddr/rf_wdata (registered write port)
module wb_write_scheduler
    import proc_pkg::*;
#(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int LINK_REG   = 31,
    parameter int STATUS_REG = 30
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              w_valid,
    input  logic [4:0]        w_opcode,
    input  logic [ADDR_W-1:0] w_rd,
    input  logic [DATA_W-1:0] w_data,
    input  logic [DATA_W-1:0] w_pc1,
    input  logic [DATA_W-1:0] w_target,
    input  logic              w_exc,
    input  logic [DATA_W-1:0] w_exc_code,
    input  logic              md_start,
    input  logic [ADDR_W-1:0] md_rd,
    input  logic              md_done,
    input  logic [DATA_W-1:0] md_result,
    input  logic              md_exc,
    input  logic [ADDR_W-1:0] d_rs,
    input  logic [ADDR_W-1:0] d_rt,
    input  logic [ADDR_W-1:0] d_rd,
    output logic              hazard,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);
    localparam logic [ADDR_W-1:0] STATUS_A = ADDR_W'(STATUS_REG);
    state_t            state, state_n;
    logic [ADDR_W-1:0] dest, buf_addr, w_addr, md_addr, md_waddr;
    logic [DATA_W-1:0] buf_data, w_wdata, md_wdata;
    logic              dec_en, w_we, md_we, md_cap;
    dsel_t             dsel;

    wb_decode #(.ADDR_W(ADDR_W), .LINK_REG(LINK_REG), .STATUS_REG(STATUS_REG)) u_dec (
        .opcode(w_opcode),
        .exc   (w_exc),
        .rd    (w_rd),
        .en    (dec_en),
        .addr  (w_addr),
        .dsel  (dsel)
    );

    always_comb begin
        w_we    = w_valid && dec_en && w_addr != '0;
        w_wdata = (dsel == DSEL_EXC) ? w_exc_code : (dsel == DSEL_PC1) ? w_pc1 :
                  (dsel == DSEL_TARGET) ? w_target : w_data;
        md_addr = md_exc ? STATUS_A : dest;
        hazard  = state != IDLE && (md_start ||
                  (dest != '0 && (d_rs == dest || d_rt == dest || d_rd == dest)));
    end

    // Mult/div source is live in BUSY and the hold buffer in HOLD; W stage always wins the port.
    always_comb begin
        state_n  = state;
        md_we    = 1'b0;
        md_cap   = 1'b0;
        md_waddr = md_addr;
        md_wdata = md_result;
        case (state)
            IDLE: state_n = md_start ? BUSY : IDLE;
            BUSY: if (md_done) begin
                state_n = w_we ? HOLD : IDLE;
                md_cap  = w_we;
                md_we   = !w_we && md_addr != '0;
            end
            HOLD: begin
                md_waddr = buf_addr;
                md_wdata = buf_data;
                state_n  = w_we ? HOLD : IDLE;
                md_we    = !w_we && buf_addr != '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            dest     <= '0;
            buf_addr <= '0;
            buf_data <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && md_start) dest <= md_rd;
            if (md_cap) begin
                buf_addr <= md_addr;
                buf_data <= md_result;
            end
            rf_we    <= w_we || md_we;
            rf_waddr <= w_we ? w_addr : md_waddr;
            rf_wdata <= w_we ? w_wdata : md_wdata;
        end
    end
endmodule

// File: tb/tb_wb_write_scheduler.sv
// tb_wb_write_scheduler: directed self-checking bench for wb_write_scheduler
module tb_wb_write_scheduler;
    import proc_pkg::*;
    logic        clock, reset_n, w_valid, w_exc, md_start, md_done, md_exc;
    logic [4:0]  w_opcode, w_rd, md_rd, d_rs, d_rt, d_rd;
    logic [31:0] w_data, w_pc1, w_target, w_exc_code, md_result;
    logic        hazard, rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [5:0]  w_rd6, md_rd6, d6;
    logic        p6_hazard, p6_we;
    logic [5:0]  p6_waddr;
    logic [31:0] p6_wdata;
    int total = 0, bad = 0;

    wb_write_scheduler dut (
        .clock(clock), .reset_n(reset_n), .w_valid(w_valid), .w_opcode(w_opcode), .w_rd(w_rd),
        .w_data(w_data), .w_pc1(w_pc1), .w_target(w_target), .w_exc(w_exc), .w_exc_code(w_exc_code),
        .md_start(md_start), .md_rd(md_rd), .md_done(md_done), .md_result(md_result), .md_exc(md_exc),
        .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd), .hazard(hazard), .rf_we(rf_we),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    wb_write_scheduler #(.ADDR_W(6), .LINK_REG(63)) dut6 (
        .clock(clock), .reset_n(reset_n), .w_valid(w_valid), .w_opcode(w_opcode), .w_rd(w_rd6),
        .w_data(w_data), .w_pc1(w_pc1), .w_target(w_target), .w_exc(w_exc), .w_exc_code(w_exc_code),
        .md_start(1'b0), .md_rd(md_rd6), .md_done(1'b0), .md_result(md_result), .md_exc(md_exc),
        .d_rs(d6), .d_rt(d6), .d_rd(d6), .hazard(p6_hazard), .rf_we(p6_we),
        .rf_waddr(p6_waddr), .rf_wdata(p6_wdata)
    );

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0; w_valid = 0; w_opcode = 0; w_rd = 0; w_data = 0; w_pc1 = 0; w_target = 0;
        w_exc = 0; w_exc_code = 0; md_start = 0; md_rd = 0; md_done = 0; md_result = 0; md_exc = 0;
        d_rs = 0; d_rt = 0; d_rd = 0; w_rd6 = 0; md_rd6 = 0; d6 = 0;
        #3;
        total++; if ({rf_we, rf_waddr, rf_wdata, hazard} !== 39'd0) begin bad++;
            $display("FAIL reset_outputs got=%0h want=0", {rf_we, rf_waddr, rf_wdata, hazard}); end
        @(negedge clock); reset_n = 1;
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_idle_we got=%0b want=0", rf_we); end
    endtask

    task automatic test_decode();
        w_valid = 1; w_opcode = OP_JAL; w_pc1 = 32'h40; w_rd = 4; w_data = 32'h11;
        tick();
        total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd31, 32'h40}) begin bad++;
            $display("FAIL jal got=%0b/%0d/%0h want=1/31/40", rf_we, rf_waddr, rf_wdata); end
        total++; if ({p6_we, p6_waddr, p6_wdata} !== {1'b1, 6'd63, 32'h40}) begin bad++;
            $display("FAIL jal_param6 got=%0b/%0d/%0h want=1/63/40", p6_we, p6_waddr, p6_wdata); end
        w_opcode = OP_SW;
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL sw_we got=%0b want=0", rf_we); end
        w_opcode = 5'b00000; w_rd = 0;
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL alu_r0_we got=%0b want=0", rf_we); end
        w_rd = 4;
        tick();
        total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h11}) begin bad++;
            $display("FAIL alu_r4 got=%0b/%0d/%0h want=1/4/11", rf_we, rf_waddr, rf_wdata); end
        w_opcode = OP_SETX; w_target = 32'h123;
        tick();
        total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd30, 32'h123}) begin bad++;
            $display("FAIL setx got=%0b/%0d/%0h want=1/30/123", rf_we, rf_waddr, rf_wdata); end
        w_opcode = OP_BEX;
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL bex_we got=%0b want=0", rf_we); end
        w_opcode = 5'b00000; w_valid = 0;
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL invalid_we got=%0b want=0", rf_we); end
    endtask

    task automatic test_exception();
        w_valid = 1; w_opcode = 5'b00000; w_rd = 5; w_exc = 1; w_exc_code = 1; w_data = 32'h77;
        tick();
        total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd30, 32'd1}) begin bad++;
            $display("FAIL exc got=%0b/%0d/%0h want=1/30/1", rf_we, rf_waddr, rf_wdata); end
        w_rd = 0; w_exc_code = 2;
        tick();
        total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd30, 32'd2}) begin bad++;
            $display("FAIL exc_r0 got=%0b/%0d/%0h want=1/30/2", rf_we, rf_waddr, rf_wdata); end
        w_valid = 0; w_exc = 0;
        tick();
    endtask

    task automatic test_hazard();
        md_start = 1; md_rd = 7;
        #1;
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL idle_start_haz got=%0b want=0", hazard); end
        tick();
        md_start = 0; d_rs = 7;
        #1;
        total++; if (hazard !== 1'b1) begin bad++; $display("FAIL haz_rs got=%0b want=1", hazard); end
        d_rs = 8;
        #1;
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL haz_rs8 got=%0b want=0", hazard); end
        d_rd = 7;
        #1;
        total++; if (hazard !== 1'b1) begin bad++; $display("FAIL haz_rd got=%0b want=1", hazard); end
        d_rd = 0; md_start = 1; md_rd = 9;
        #1;
        total++; if (hazard !== 1'b1) begin bad++; $display("FAIL haz_restart got=%0b want=1", hazard); end
        tick();
        md_start = 0; md_done = 1; md_result = 32'h99; d_rs = 7;
        tick();
        md_done = 0;
        total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h99}) begin bad++;
            $display("FAIL md_free got=%0b/%0d/%0h want=1/7/99", rf_we, rf_waddr, rf_wdata); end
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL haz_clear got=%0b want=0", hazard); end
        d_rs = 0;
    endtask

    task automatic test_collision();
        md_start = 1; md_rd = 7;
        tick();
        md_start = 0; md_done = 1; md_result = 32'h55;
        w_valid = 1; w_opcode = 5'b00000; w_rd = 3; w_data = 32'h33; d_rs = 7;
        tick();
        md_done = 0;
        total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h33}) begin bad++;
            $display("FAIL coll_w got=%0b/%0d/%0h want=1/3/33", rf_we, rf_waddr, rf_wdata); end
        total++; if (hazard !== 1'b1) begin bad++; $display("FAIL hold_haz got=%0b want=1", hazard); end
        w_rd = 4; w_data = 32'h44;
        tick();
        total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h44}) begin bad++;
            $display("FAIL hold_w2 got=%0b/%0d/%0h want=1/4/44", rf_we, rf_waddr, rf_wdata); end
        w_valid = 0;
        tick();
        total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h55}) begin bad++;
            $display("FAIL drain got=%0b/%0d/%0h want=1/7/55", rf_we, rf_waddr, rf_wdata); end
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL drain_haz got=%0b want=0", hazard); end
        tick();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL drain_once got=%0b want=0", rf_we); end
        d_rs = 0;
    endtask

    task automatic test_md_special();
        md_start = 1; md_rd = 9;
        tick();
        md_start = 0; md_done = 1; md_exc = 1; md_result = 32'hAB;
        tick();
        md_done = 0; md_exc = 0;
        total++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd30, 32'hAB}) begin bad++;
            $display("FAIL md_exc got=%0b/%0d/%0h want=1/30/ab", rf_we, rf_waddr, rf_wdata); end
        md_start = 1; md_rd = 0;
        tick();
        md_start = 0; d_rs = 0;
        #1;
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL haz_r0 got=%0b want=0", hazard); end
        md_done = 1; md_result = 32'hCD;
        tick();
        md_done = 0;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL md_r0 got=%0b want=0", rf_we); end
    endtask

    task automatic test_reset_mid();
        md_start = 1; md_rd = 7; w_valid = 1; w_opcode = 5'b00000; w_rd = 3; w_data = 32'h3;
        tick();
        md_start = 0; w_valid = 0; d_rs = 7;
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL pre_reset_we got=%0b want=1", rf_we); end
        #2 reset_n = 0;
        #1;
        total++; if ({rf_we, rf_waddr, rf_wdata, hazard} !== 39'd0) begin bad++;
            $display("FAIL midreset_outputs got=%0h want=0", {rf_we, rf_waddr, rf_wdata, hazard}); end
        #1 reset_n = 1;
        md_done = 1; md_result = 32'hEE;
        tick();
        md_done = 0;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL post_reset_done got=%0b want=0", rf_we); end
        total++; if (hazard !== 1'b0) begin bad++; $display("FAIL post_reset_haz got=%0b want=0", hazard); end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_exception();
        test_hazard();
        test_collision();
        test_md_special();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
